// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready flow control, a two-entry skid buffer,
// flush-to-bubble and a saturating stall counter.
module pipe_stage_skid #(
  parameter int CTRL_W      = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter bit CLEAR_CTRL  = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_alu,
  input  logic [DATA_W-1:0]      in_rtdata,
  input  logic [ADDR_W-1:0]      in_dst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_alu,
  output logic [DATA_W-1:0]      out_rtdata,
  output logic [ADDR_W-1:0]      out_dst,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CTRL_W-1:0]      mainCtrl_q, mainCtrl_d;
  logic [DATA_W-1:0]      mainAlu_q, mainAlu_d;
  logic [DATA_W-1:0]      mainRt_q, mainRt_d;
  logic [ADDR_W-1:0]      mainDst_q, mainDst_d;
  logic [CTRL_W-1:0]      skidCtrl_q, skidCtrl_d;
  logic [DATA_W-1:0]      skidAlu_q, skidAlu_d;
  logic [DATA_W-1:0]      skidRt_q, skidRt_d;
  logic [ADDR_W-1:0]      skidDst_q, skidDst_d;
  logic [STALL_CNT_W-1:0] stallCnt_q, stallCnt_d;

  logic accept;
  logic pop;

  // in_ready depends on the state register only, so out_ready never reaches upstream.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    mainCtrl_d = mainCtrl_q;
    mainAlu_d  = mainAlu_q;
    mainRt_d   = mainRt_q;
    mainDst_d  = mainDst_q;
    skidCtrl_d = skidCtrl_q;
    skidAlu_d  = skidAlu_q;
    skidRt_d   = skidRt_q;
    skidDst_d  = skidDst_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            mainCtrl_d = in_ctrl;
            mainAlu_d  = in_alu;
            mainRt_d   = in_rtdata;
            mainDst_d  = in_dst;
            state_d    = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            mainCtrl_d = in_ctrl;
            mainAlu_d  = in_alu;
            mainRt_d   = in_rtdata;
            mainDst_d  = in_dst;
          end else if (accept) begin
            skidCtrl_d = in_ctrl;
            skidAlu_d  = in_alu;
            skidRt_d   = in_rtdata;
            skidDst_d  = in_dst;
            state_d    = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            mainCtrl_d = skidCtrl_q;
            mainAlu_d  = skidAlu_q;
            mainRt_d   = skidRt_q;
            mainDst_d  = skidDst_q;
            state_d    = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (out_valid && !out_ready && (stallCnt_q != {STALL_CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      mainCtrl_q <= '0;
      mainAlu_q  <= '0;
      mainRt_q   <= '0;
      mainDst_q  <= '0;
      skidCtrl_q <= '0;
      skidAlu_q  <= '0;
      skidRt_q   <= '0;
      skidDst_q  <= '0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mainCtrl_q <= mainCtrl_d;
      mainAlu_q  <= mainAlu_d;
      mainRt_q   <= mainRt_d;
      mainDst_q  <= mainDst_d;
      skidCtrl_q <= skidCtrl_d;
      skidAlu_q  <= skidAlu_d;
      skidRt_q   <= skidRt_d;
      skidDst_q  <= skidDst_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  // With CLEAR_CTRL a bubble presents an all-zero control bundle, i.e. a NOP.
  if (CLEAR_CTRL) begin : g_clearCtrl
    assign out_ctrl = out_valid ? mainCtrl_q : '0;
  end else begin : g_passCtrl
    assign out_ctrl = mainCtrl_q;
  end

  assign out_alu    = mainAlu_q;
  assign out_rtdata = mainRt_q;
  assign out_dst    = mainDst_q;
  assign stall_cnt  = stallCnt_q;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-width EX/MEM stage register.
- Carries a control/ALU-result/store-data/destination-register bundle between two pipeline stages.
- Adds valid/ready flow control, a 2-entry skid buffer so backpressure does not cost throughput, flush (bubble insertion) and a saturating stall counter.
- Used between any two CPU stages where the downstream stage may stall.

Parameters:
CTRL_W, 4, width of control bundle
DATA_W, 32, width of ALU result and store-data fields
ADDR_W, 5, width of destination register address
CLEAR_CTRL, 1, 1: out_ctrl forced to 0 whenever out_valid=0 (bubble is a NOP)
STALL_CNT_W, 16, width of stall counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  discard all held and incoming beats
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_ctrl  input  CTRL_W  control bundle
in_alu  input  DATA_W  ALU result
in_rtdata  input  DATA_W  store data
in_dst  input  ADDR_W  destination register (Rt/Rd)
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts beat
out_ctrl  output  CTRL_W  control bundle
out_alu  output  DATA_W  ALU result
out_rtdata  output  DATA_W  store data
out_dst  output  ADDR_W  destination register
stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Clock and reset: single clock clk; rst asynchronous active-high; no synchronous reset path.
- Storage: main entry (drives out_*) and skid entry.
- State machine: EMPTY, ONE (main valid), TWO (main and skid valid).
- Handshake definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (state != TWO), decoded from the state register only, with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- Transitions without flush:
  - EMPTY: accept -> main<=in, ONE; else stay.
  - ONE: accept&pop -> main<=in, ONE; accept&!pop -> skid<=in, TWO; !accept&pop -> EMPTY; else hold.
  - TWO: pop -> main<=skid, ONE; else hold. No accept is possible because in_ready=0.
- Latency and throughput: 1 cycle from accept to out_valid. Full throughput (1 beat/cycle) when out_ready is held 1. Beat order is always preserved.
- Data holding: out_alu, out_rtdata and out_dst hold stable while out_valid=1 and out_ready=0.
- Flush:
  - Next state = EMPTY unconditionally.
  - A beat accepted in the flush cycle is dropped; upstream treats it as consumed.
  - A pop in the flush cycle still completes, because downstream has already sampled it.
  - Flush while EMPTY has no effect.
- Control gating: when CLEAR_CTRL=1, out_ctrl = 0 whenever out_valid=0. Data fields may hold stale values while out_valid=0. When CLEAR_CTRL=0, out_ctrl reflects the main entry regardless of out_valid.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at all-ones; no wrap.
  - Not affected by flush; cleared only by rst.
- Reset values: state EMPTY; main and skid registers all 0; out_valid=0, in_ready=1, out_ctrl/out_alu/out_rtdata/out_dst=0, stall_cnt=0.
- Reset mid-operation: held beats are lost and outputs go to reset values immediately (asynchronous). First accept is possible on the first clock edge after rst deasserts.
- X handling: in_* fields are ignored when in_valid=0; they must never propagate to outputs.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, out_ctrl=0, stall_cnt=0. Assert rst mid-cycle -> outputs clear before the next edge.
- Single beat ctrl=4'hA, alu=32'h1234_5678, dst=5'd9, with out_ready=1 -> out_valid=1 exactly one cycle later with identical fields; EMPTY the following cycle.
- Stream of 8 beats, alu=0..7, with out_ready=1 -> outputs 0..7 on consecutive cycles, no bubbles, in_ready constantly 1.
- Beats alu=1,2,3 with out_ready=0 from cycle 1:
  - out holds 1; in_ready drops after beat 2 (TWO); beat 3 is held upstream.
  - Release out_ready -> order 1,2,3, no loss or duplication.
  - stall_cnt equals the number of stalled cycles.
- In TWO state, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1. Both held beats and the in-flight beat never appear.
- STALL_CNT_W=4, hold a valid beat with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays. Flush -> stall_cnt unchanged.
